// File: rtl/deflate_bit_reader.sv
//==============================================================================
// Module      : deflate_bit_reader
// Description : LSB-first DEFLATE bit buffer serving variable-length bit
//               requests, byte-align requests and end-of-stream underflow.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module deflate_bit_reader #(
  parameter int MAX_BITS = 16,
  parameter int BUF_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          in_byte,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  input  logic                req_valid,
  input  logic [4:0]          req_len,
  input  logic                req_align,
  output logic                req_ready,
  output logic                rsp_valid,
  output logic [MAX_BITS-1:0] rsp_bits,
  output logic                rsp_err,
  output logic [5:0]          bits_avail,
  output logic [31:0]         bits_consumed
);

  localparam logic [5:0] c_max_len  = 6'(MAX_BITS);
  localparam logic [5:0] c_fill_max = 6'(BUF_W - 8);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t              r_state;
  logic [BUF_W-1:0]    r_buf;
  logic [5:0]          r_cnt;
  logic                r_eos;
  logic [4:0]          r_len;
  logic                r_rsp_valid;
  logic [MAX_BITS-1:0] r_rsp_bits;
  logic                r_rsp_err;
  logic [31:0]         r_consumed;

  state_t              w_state_nxt;
  logic [4:0]          w_len_nxt;
  logic                w_act;
  logic [4:0]          w_len;
  logic                w_align;
  logic                w_illegal;
  logic                w_enough;
  logic                w_serve;
  logic                w_err;
  logic [5:0]          w_take;
  logic [2:0]          w_drop;
  logic [MAX_BITS-1:0] w_bits;
  logic                w_in_ready;
  logic                w_accept;
  logic [5:0]          w_pos;
  logic [BUF_W-1:0]    w_byte_ext;
  logic [BUF_W-1:0]    w_buf_nxt;
  logic [5:0]          w_cnt_nxt;

  // Bits needed to reach the next byte boundary of the stream.
  assign w_drop     = 3'd0 - r_consumed[2:0];
  assign w_in_ready = !r_eos && (r_cnt <= c_fill_max);
  assign w_accept   = in_valid && w_in_ready;
  assign w_byte_ext = {{(BUF_W-8){1'b0}}, in_byte};

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_act       = (r_state == ST_WAIT) || req_valid;
    w_len       = (r_state == ST_WAIT) ? r_len : req_len;
    w_align     = (r_state == ST_IDLE) && req_valid && req_align;
    w_illegal   = (r_state == ST_IDLE) && req_valid && !req_align &&
                  ((req_len == 5'd0) || ({1'b0, req_len} > c_max_len));
    w_enough    = ({1'b0, w_len} <= r_cnt);
    w_serve     = w_act && (w_align || w_illegal || w_enough || r_eos);
    w_take      = 6'd0;
    w_err       = 1'b0;

    if (w_serve) begin
      if (w_align) begin
        w_take = {3'b000, w_drop};
      end else if (w_illegal) begin
        w_err = 1'b1;
      end else if (w_enough) begin
        w_take = {1'b0, w_len};
      end else begin
        // End of stream with too few bits: hand back whatever remains.
        w_take = r_cnt;
        w_err  = 1'b1;
      end
    end

    case (r_state)
      ST_IDLE: begin
        if (req_valid && !w_serve) begin
          w_state_nxt = ST_WAIT;
          w_len_nxt   = req_len;
        end
      end
      ST_WAIT: begin
        if (w_serve) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_bits = '0;
    for (int i = 0; i < MAX_BITS; i++) begin
      w_bits[i] = r_buf[i] && (6'(i) < w_take) && !w_align;
    end
  end

  // New byte lands directly above the bits that survive this cycle's consume.
  assign w_pos     = r_cnt - w_take;
  assign w_buf_nxt = (r_buf >> w_take) | (w_accept ? (w_byte_ext << w_pos) : '0);
  assign w_cnt_nxt = w_pos + (w_accept ? 6'd8 : 6'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_buf       <= '0;
      r_cnt       <= 6'd0;
      r_eos       <= 1'b0;
      r_len       <= 5'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_bits  <= '0;
      r_rsp_err   <= 1'b0;
      r_consumed  <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_buf       <= w_buf_nxt;
      r_cnt       <= w_cnt_nxt;
      r_eos       <= r_eos | (w_accept & in_last);
      r_len       <= w_len_nxt;
      r_rsp_valid <= w_serve;
      r_consumed  <= r_consumed + {26'd0, w_take};
      if (w_serve) begin
        r_rsp_bits <= w_bits;
        r_rsp_err  <= w_err;
      end
    end
  end

  assign in_ready      = w_in_ready;
  assign req_ready     = (r_state == ST_IDLE);
  assign rsp_valid     = r_rsp_valid;
  assign rsp_bits      = r_rsp_bits;
  assign rsp_err       = r_rsp_err;
  assign bits_avail    = r_cnt;
  assign bits_consumed = r_consumed;

endmodule

`default_nettype wire

// File: tb/tb_deflate_bit_reader.sv
//==============================================================================
// Module      : tb_deflate_bit_reader
// Description : Self-checking bench: vector table, directed corner sequences
//               and randomized traffic against a bit-queue reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_deflate_bit_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_byte = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        req_valid = 1'b0;
  logic [4:0]  req_len = 5'd0;
  logic        req_align = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_bits;
  logic        rsp_err;
  logic [5:0]  bits_avail;
  logic [31:0] bits_consumed;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  deflate_bit_reader #(.MAX_BITS(16), .BUF_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .req_valid(req_valid), .req_len(req_len), .req_align(req_align), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_bits(rsp_bits), .rsp_err(rsp_err),
    .bits_avail(bits_avail), .bits_consumed(bits_consumed)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic iv, input logic [7:0] b, input logic last,
                        input logic rv, input logic [4:0] len, input logic al);
    in_valid = iv; in_byte = b; in_last = last;
    req_valid = rv; req_len = len; req_align = al;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: stream bits held LSB-first in a queue.
  bit          m_q[$];
  bit          m_eos;
  bit          m_wait;
  int          m_len;
  int unsigned m_cons;
  bit          m_rv;
  logic [15:0] m_bits;
  bit          m_err;

  task automatic model_reset();
    m_q.delete();
    m_eos = 0; m_wait = 0; m_len = 0; m_cons = 0;
    m_rv = 0; m_bits = '0; m_err = 0;
  endtask

  task automatic pop_bits(input int n, output logic [15:0] v);
    v = '0;
    for (int i = 0; i < n; i++) v[i] = m_q.pop_front();
    m_cons += n;
  endtask

  task automatic model_step();
    bit acc;
    bit al;
    int len;
    int n;
    logic [15:0] v;
    acc = in_valid && !m_eos && (m_q.size() <= 24);
    m_rv = 0;
    if (m_wait || req_valid) begin
      len = m_wait ? m_len : int'(req_len);
      al  = !m_wait && req_align;
      if (al) begin
        n = int'((8 - (m_cons % 8)) % 8);
        pop_bits(n, v);
        m_rv = 1; m_bits = '0; m_err = 0; m_wait = 0;
      end else if (len == 0 || len > 16) begin
        m_rv = 1; m_bits = '0; m_err = 1; m_wait = 0;
      end else if (m_q.size() >= len) begin
        pop_bits(len, v);
        m_rv = 1; m_bits = v; m_err = 0; m_wait = 0;
      end else if (m_eos) begin
        pop_bits(m_q.size(), v);
        m_rv = 1; m_bits = v; m_err = 1; m_wait = 0;
      end else begin
        m_wait = 1; m_len = len;
      end
    end
    if (acc) begin
      for (int i = 0; i < 8; i++) m_q.push_back(in_byte[i]);
      if (in_last) m_eos = 1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(m_rv));
    chk({tag, "_rsp_bits"}, 32'(rsp_bits), 32'(m_bits));
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(m_err));
    chk({tag, "_bits_avail"}, 32'(bits_avail), 32'(m_q.size()));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(!m_eos && (m_q.size() <= 24)));
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(!m_wait));
    chk({tag, "_bits_consumed"}, bits_consumed, m_cons);
  endtask

  task automatic do_reset();
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic        iv;
    logic [7:0]  b;
    logic        rv;
    logic [4:0]  len;
    logic        al;
    logic        ev;
    logic [15:0] eb;
    logic        ee;
    logic [5:0]  ea;
    logic [31:0] ec;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic iv, input logic [7:0] b, input logic rv,
                     input logic [4:0] len, input logic al, input logic ev,
                     input logic [15:0] eb, input logic ee, input logic [5:0] ea,
                     input logic [31:0] ec);
    vec_t v;
    v.iv = iv; v.b = b; v.rv = rv; v.len = len; v.al = al;
    v.ev = ev; v.eb = eb; v.ee = ee; v.ea = ea; v.ec = ec;
    tbl.push_back(v);
  endtask

  initial begin
    int r;

    //        iv    byte    rv    len    al    ev    bits      err   avail   consumed
    add(1'b1, 8'hA5, 1'b0, 5'd0,  1'b0, 1'b0, 16'h0000, 1'b0, 6'd8,  32'd0);
    add(1'b1, 8'h3C, 1'b0, 5'd0,  1'b0, 1'b0, 16'h0000, 1'b0, 6'd16, 32'd0);
    add(1'b0, 8'h00, 1'b1, 5'd3,  1'b0, 1'b1, 16'h0005, 1'b0, 6'd13, 32'd3);
    add(1'b0, 8'h00, 1'b1, 5'd9,  1'b0, 1'b1, 16'h0194, 1'b0, 6'd4,  32'd12);
    add(1'b0, 8'h00, 1'b1, 5'd0,  1'b1, 1'b1, 16'h0000, 1'b0, 6'd0,  32'd16);
    add(1'b0, 8'h00, 1'b0, 5'd0,  1'b0, 1'b0, 16'h0000, 1'b0, 6'd0,  32'd16);
    add(1'b1, 8'hA5, 1'b0, 5'd0,  1'b0, 1'b0, 16'h0000, 1'b0, 6'd8,  32'd16);
    add(1'b1, 8'h3C, 1'b0, 5'd0,  1'b0, 1'b0, 16'h0000, 1'b0, 6'd16, 32'd16);
    add(1'b0, 8'h00, 1'b1, 5'd3,  1'b0, 1'b1, 16'h0005, 1'b0, 6'd13, 32'd19);
    add(1'b0, 8'h00, 1'b1, 5'd0,  1'b1, 1'b1, 16'h0000, 1'b0, 6'd8,  32'd24);
    add(1'b0, 8'h00, 1'b1, 5'd8,  1'b0, 1'b1, 16'h003C, 1'b0, 6'd0,  32'd32);
    add(1'b0, 8'h00, 1'b1, 5'd0,  1'b0, 1'b1, 16'h0000, 1'b1, 6'd0,  32'd32);
    add(1'b0, 8'h00, 1'b1, 5'd17, 1'b0, 1'b1, 16'h0000, 1'b1, 6'd0,  32'd32);
    add(1'b0, 8'h00, 1'b1, 5'd0,  1'b1, 1'b1, 16'h0000, 1'b0, 6'd0,  32'd32);
    add(1'b1, 8'h5A, 1'b0, 5'd0,  1'b0, 1'b0, 16'h0000, 1'b0, 6'd8,  32'd32);
    add(1'b1, 8'hC3, 1'b1, 5'd4,  1'b0, 1'b1, 16'h000A, 1'b0, 6'd12, 32'd36);
    add(1'b0, 8'h00, 1'b1, 5'd12, 1'b0, 1'b1, 16'h0C35, 1'b0, 6'd0,  32'd48);

    do_reset();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_bits", 32'(rsp_bits), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_bits_avail", 32'(bits_avail), 32'd0);
    chk("reset_bits_consumed", bits_consumed, 32'd0);

    foreach (tbl[k]) begin
      set_in(tbl[k].iv, tbl[k].b, 1'b0, tbl[k].rv, tbl[k].len, tbl[k].al);
      tick();
      chk($sformatf("vec%0d_rsp_valid", k), 32'(rsp_valid), 32'(tbl[k].ev));
      chk($sformatf("vec%0d_rsp_bits", k), 32'(rsp_bits), 32'(tbl[k].eb));
      chk($sformatf("vec%0d_rsp_err", k), 32'(rsp_err), 32'(tbl[k].ee));
      chk($sformatf("vec%0d_bits_avail", k), 32'(bits_avail), 32'(tbl[k].ea));
      chk($sformatf("vec%0d_bits_consumed", k), bits_consumed, tbl[k].ec);
    end

    // Request from an empty buffer stalls until two bytes have arrived.
    do_reset();
    set_in(1'b0, 8'h00, 1'b0, 1'b1, 5'd16, 1'b0); tick();
    chk("wait_req_ready", 32'(req_ready), 32'd0);
    chk("wait_no_rsp0", 32'(rsp_valid), 32'd0);
    set_in(1'b1, 8'h34, 1'b0, 1'b0, 5'd0, 1'b0); tick();
    chk("wait_no_rsp1", 32'(rsp_valid), 32'd0);
    set_in(1'b1, 8'h12, 1'b0, 1'b0, 5'd0, 1'b0); tick();
    chk("wait_no_rsp2", 32'(rsp_valid), 32'd0);
    chk("wait_avail", 32'(bits_avail), 32'd16);
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0); tick();
    chk("wait_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wait_rsp_bits", 32'(rsp_bits), 32'h1234);
    chk("wait_rsp_err", 32'(rsp_err), 32'd0);
    chk("wait_req_ready_back", 32'(req_ready), 32'd1);

    // Full buffer, consume while a byte is held waiting.
    do_reset();
    set_in(1'b1, 8'h11, 1'b0, 1'b0, 5'd0, 1'b0); tick();
    set_in(1'b1, 8'h22, 1'b0, 1'b0, 5'd0, 1'b0); tick();
    set_in(1'b1, 8'h33, 1'b0, 1'b0, 5'd0, 1'b0); tick();
    set_in(1'b1, 8'h44, 1'b0, 1'b0, 5'd0, 1'b0); tick();
    chk("full_avail", 32'(bits_avail), 32'd32);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    set_in(1'b1, 8'h55, 1'b0, 1'b1, 5'd8, 1'b0); tick();
    chk("full_rsp_bits", 32'(rsp_bits), 32'h11);
    chk("full_avail_after", 32'(bits_avail), 32'd24);
    chk("full_in_ready_after", 32'(in_ready), 32'd1);
    set_in(1'b1, 8'h55, 1'b0, 1'b0, 5'd0, 1'b0); tick();
    chk("full_refill_avail", 32'(bits_avail), 32'd32);
    set_in(1'b0, 8'h00, 1'b0, 1'b1, 5'd16, 1'b0); tick();
    chk("full_order0", 32'(rsp_bits), 32'h3322);
    set_in(1'b0, 8'h00, 1'b0, 1'b1, 5'd16, 1'b0); tick();
    chk("full_order1", 32'(rsp_bits), 32'h5544);
    chk("full_drained", 32'(bits_avail), 32'd0);

    // Underflow at end of stream.
    do_reset();
    set_in(1'b1, 8'hFF, 1'b1, 1'b0, 5'd0, 1'b0); tick();
    chk("eos_in_ready", 32'(in_ready), 32'd0);
    set_in(1'b0, 8'h00, 1'b0, 1'b1, 5'd12, 1'b0); tick();
    chk("uf_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("uf_rsp_err", 32'(rsp_err), 32'd1);
    chk("uf_rsp_bits", 32'(rsp_bits), 32'h0FF);
    chk("uf_avail", 32'(bits_avail), 32'd0);
    chk("uf_in_ready", 32'(in_ready), 32'd0);
    chk("uf_consumed", bits_consumed, 32'd8);

    // Asynchronous reset while a request is stalled.
    do_reset();
    set_in(1'b1, 8'hAB, 1'b0, 1'b0, 5'd0, 1'b0); tick();
    set_in(1'b0, 8'h00, 1'b0, 1'b1, 5'd3, 1'b0); tick();
    chk("mr_rsp_bits_pre", 32'(rsp_bits), 32'h3);
    set_in(1'b0, 8'h00, 1'b0, 1'b1, 5'd16, 1'b0); tick();
    chk("mr_in_wait", 32'(req_ready), 32'd0);
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    chk("mr_req_ready", 32'(req_ready), 32'd1);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mr_rsp_bits", 32'(rsp_bits), 32'd0);
    chk("mr_rsp_err", 32'(rsp_err), 32'd0);
    chk("mr_avail", 32'(bits_avail), 32'd0);
    chk("mr_consumed", bits_consumed, 32'd0);
    tick();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mr_post_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mr_post_req_ready", 32'(req_ready), 32'd1);
      chk("mr_post_consumed", bits_consumed, 32'd0);
    end

    // Randomized traffic against the reference model.
    for (int seg = 0; seg < 8; seg++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        in_valid  = ($urandom % 4) != 0;
        in_byte   = 8'($urandom);
        in_last   = ($urandom % 150) == 0;
        req_valid = !m_wait && (($urandom % 3) == 0);
        req_align = ($urandom % 10) == 0;
        r = int'($urandom % 20);
        req_len = (r < 2) ? 5'(r * 17) : 5'($urandom_range(1, 16));
        model_step();
        tick();
        check_model("rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
